// File: rtl/arm_pipelined_mul_flag_unit.sv
// Iterative MUL/MLA/UMULL/SMULL unit for the Execute stage.
// Retires BITS_PER_CYCLE multiplier bits per cycle and reports NZ flag updates on completion.
module arm_pipelined_mul_flag_unit #(
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic        i_CLK,
  input  logic        i_NRESET,
  input  logic        i_Start,
  input  logic [1:0]  i_Op,
  input  logic        i_SetFlags,
  input  logic        i_Flush,
  input  logic [31:0] i_Rm,
  input  logic [31:0] i_Rs,
  input  logic [31:0] i_Rn,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [31:0] o_ResultLo,
  output logic [31:0] o_ResultHi,
  output logic [1:0]  o_Flag_Write,
  output logic [3:0]  o_Flags
);

  localparam int unsigned STEPS = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MLA   = 2'b01;
  localparam logic [1:0] OP_SMULL = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             setf_q, setf_d;
  logic             neg_q, neg_d;
  logic [31:0]      rn_q, rn_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [63:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [1:0]       fw_q, fw_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic [63:0] partial;
  logic [63:0] signed_v;
  logic [31:0] final_lo;
  logic [31:0] final_hi;
  logic        res_n;
  logic        res_z;
  logic        start_ok;
  logic [31:0] rm_mag;
  logic [31:0] rs_mag;

  // Partial product of the shifted multiplicand and the low multiplier slice.
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  // Final value after sign restoration and accumulate, plus its NZ flags.
  always_comb begin
    signed_v = neg_q ? (~acc_q + 64'd1) : acc_q;
    final_lo = signed_v[31:0] + ((op_q == OP_MLA) ? rn_q : 32'd0);
    final_hi = op_q[1] ? signed_v[63:32] : 32'd0;
    res_n    = op_q[1] ? final_hi[31] : final_lo[31];
    res_z    = op_q[1] ? ({final_hi, final_lo} == 64'd0) : (final_lo == 32'd0);
  end

  assign start_ok = i_Start && !i_Flush;
  assign rm_mag   = ((i_Op == OP_SMULL) && i_Rm[31]) ? (~i_Rm + 32'd1) : i_Rm;
  assign rs_mag   = ((i_Op == OP_SMULL) && i_Rs[31]) ? (~i_Rs + 32'd1) : i_Rs;

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      setf_q   <= 1'b0;
      neg_q    <= 1'b0;
      rn_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      fw_q     <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      setf_q   <= setf_d;
      neg_q    <= neg_d;
      rn_q     <= rn_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      fw_q     <= fw_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath control; flag outputs default to cleared.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    setf_d   = setf_q;
    neg_d    = neg_q;
    rn_d     = rn_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    fw_d     = 2'b00;
    flags_d  = 4'b0000;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          op_d     = i_Op;
          setf_d   = i_SetFlags;
          neg_d    = (i_Op == OP_SMULL) && (i_Rm[31] ^ i_Rs[31]);
          rn_d     = i_Rn;
          mcand_d  = {32'd0, rm_mag};
          mplier_d = rs_mag;
          acc_d    = '0;
          cnt_d    = CNT_W'(STEPS);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (i_Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_q + partial;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (i_Flush) begin
          state_d = S_IDLE;
        end else begin
          lo_d    = final_lo;
          hi_d    = final_hi;
          flags_d = {res_n, res_z, 2'b00};
          fw_d    = setf_q ? 2'b10 : 2'b00;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Busy asserts combinationally in the accepting IDLE cycle so Execute stalls at once.
  assign o_Busy = i_NRESET && ((state_q == S_CALC) || (state_q == S_FINISH) ||
                               ((state_q == S_IDLE) && start_ok));

  assign o_Done       = done_q;
  assign o_ResultLo   = lo_q;
  assign o_ResultHi   = hi_q;
  assign o_Flag_Write = fw_q;
  assign o_Flags      = flags_q;

endmodule
